txepad: RTL and testbench

Transmit-side minimum-frame enforcer for the Ethernet MII nibble path. It pads frames shorter than MINNIBBLES nibbles (60 bytes before CRC) with zero nibbles, and enforces an inter-frame gap before the next frame may start. It sits between the transmit packet source and the CRC appender, and runs on the same nibble-rate i_ce strobe.

---
 rtl/txepad_pkg.sv | 19 +
 rtl/txepad.sv | 121 ++++++++++++
 tb/tb_txepad.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/txepad_pkg.sv
// Shared types for the transmit minimum-frame padder.
// Holds the state enum and the counter-width helper.
package txepad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAD  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // Smallest width able to hold max(a, b).
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/txepad.sv
// Transmit minimum-frame enforcer on the MII nibble path.
// Pads short frames with zero nibbles and forces an inter-frame gap.
// Ports: i_clk, i_reset (sync, active high), i_ce nibble strobe,
//   i_en pad enable, i_cancel abort, i_v/i_d upstream nibble,
//   o_v/o_d output nibble, o_busy (PAD/GAP), o_err sticky violation.
module txepad
    import txepad_pkg::*;
#(
    parameter int MINNIBBLES = 120,
    parameter int IFGNIBBLES = 24
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ce,
    input  logic       i_en,
    input  logic       i_cancel,
    input  logic       i_v,
    input  logic [3:0] i_d,
    output logic       o_v,
    output logic [3:0] o_d,
    output logic       o_busy,
    output logic       o_err
);

    localparam int LGNCOUNT = cnt_width(MINNIBBLES, IFGNIBBLES);
    localparam logic [LGNCOUNT-1:0] NMIN = LGNCOUNT'(MINNIBBLES);
    localparam logic [LGNCOUNT-1:0] NIFG = LGNCOUNT'(IFGNIBBLES);

    state_t              state, state_nx;
    logic [LGNCOUNT-1:0] ncnt, ncnt_nx, ncnt_inc;
    logic [LGNCOUNT-1:0] gcnt, gcnt_nx, gcnt_inc;
    logic                last_v;
    logic                v_nx;
    logic [3:0]          d_nx;
    logic                err_nx;

    assign ncnt_inc = ncnt + 1'b1;
    assign gcnt_inc = gcnt + 1'b1;

    always_comb begin
        state_nx = state;
        ncnt_nx  = ncnt;
        gcnt_nx  = gcnt;
        v_nx     = 1'b0;
        d_nx     = 4'h0;
        err_nx   = o_err;
        unique case (state)
            ST_IDLE: begin
                // A frame starts only on a rising edge of i_v.
                if (i_v && !last_v && !i_cancel) begin
                    v_nx     = 1'b1;
                    d_nx     = i_d;
                    ncnt_nx  = LGNCOUNT'(1);
                    err_nx   = 1'b0;
                    state_nx = ST_DATA;
                end
            end
            ST_DATA: begin
                if (i_cancel) begin
                    gcnt_nx  = '0;
                    state_nx = ST_GAP;
                end else if (i_v) begin
                    v_nx = 1'b1;
                    d_nx = i_d;
                    if (ncnt < NMIN) ncnt_nx = ncnt_inc;
                end else if (i_en && (ncnt < NMIN)) begin
                    v_nx     = 1'b1;
                    ncnt_nx  = ncnt_inc;
                    gcnt_nx  = '0;
                    state_nx = (ncnt_inc == NMIN) ? ST_GAP : ST_PAD;
                end else begin
                    gcnt_nx  = '0;
                    state_nx = ST_GAP;
                end
            end
            ST_PAD: begin
                if (i_v) err_nx = 1'b1;
                if (i_cancel) begin
                    gcnt_nx  = '0;
                    state_nx = ST_GAP;
                end else begin
                    v_nx    = 1'b1;
                    ncnt_nx = ncnt_inc;
                    if (ncnt_inc == NMIN) begin
                        gcnt_nx  = '0;
                        state_nx = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (i_v) err_nx = 1'b1;
                gcnt_nx = gcnt_inc;
                if (gcnt_inc == NIFG) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state  <= ST_IDLE;
            ncnt   <= '0;
            gcnt   <= '0;
            last_v <= 1'b0;
            o_v    <= 1'b0;
            o_d    <= 4'h0;
            o_busy <= 1'b0;
            o_err  <= 1'b0;
        end else if (i_ce) begin
            state  <= state_nx;
            ncnt   <= ncnt_nx;
            gcnt   <= gcnt_nx;
            last_v <= i_v;
            o_v    <= v_nx;
            o_d    <= d_nx;
            o_busy <= (state_nx == ST_PAD) || (state_nx == ST_GAP);
            o_err  <= err_nx;
        end
    end

endmodule

// File: tb/tb_txepad.sv
// Self-checking bench for txepad.
// Expected outputs are derived per frame from length/enable/cancel rules.
module tb_txepad;

    localparam int MIN = 120;
    localparam int IFG = 24;

    logic       clk = 1'b0;
    logic       rst, ce, en, cancel, iv;
    logic [3:0] id;
    logic       ov, busy, err;
    logic [3:0] od;

    always #5 clk = ~clk;

    txepad dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_ce    (ce),
        .i_en    (en),
        .i_cancel(cancel),
        .i_v     (iv),
        .i_d     (id),
        .o_v     (ov),
        .o_d     (od),
        .o_busy  (busy),
        .o_err   (err)
    );

    typedef struct {
        bit         ce;
        bit         v;
        logic [3:0] d;
        bit         chk_d;
        bit         busy;
        bit         err;
        bit         clr;
        bit         lit;
        int         lit_v;
        int         lit_b;
    } exp_t;

    exp_t q[$];
    exp_t cx;
    exp_t last_exp;
    int   total  = 0;
    int   passed = 0;
    int   nfail  = 0;
    int   vc     = 0;
    int   bc     = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else begin
            nfail++;
            if (nfail <= 40)
                $display("FAIL %s: got %0d, want %0d at %0t",
                         name, act, req, $time);
        end
    endtask

    // Single compare process: one expected entry per clock.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            cx = q.pop_front();
            if (cx.clr) begin
                vc = 0;
                bc = 0;
            end
            chk("o_v", int'(ov), int'(cx.v));
            chk("o_busy", int'(busy), int'(cx.busy));
            chk("o_err", int'(err), int'(cx.err));
            if (cx.chk_d) chk("o_d", int'(od), int'(cx.d));
            if (cx.ce) begin
                vc += int'(ov);
                bc += int'(busy);
            end
            if (cx.lit) begin
                chk("vcount", vc, cx.lit_v);
                chk("busycount", bc, cx.lit_b);
            end
        end
    end

    function automatic logic [3:0] pat(input int t, input int s);
        return 4'(((t * 5 + s) % 15) + 1);
    endfunction

    task automatic step(input bit c, input bit r, input bit v,
                        input logic [3:0] d, input bit can,
                        input bit e_n, input exp_t x);
        @(negedge clk);
        ce     = c;
        rst    = r;
        iv     = v;
        id     = d;
        cancel = can;
        en     = e_n;
        q.push_back(x);
    endtask

    // One frame: n nibbles, pad enable, cancel at ce c, i_v injected at
    // ces [e, e+k), en flipped after data, ce every div clocks,
    // reset at ce rst_at. Ends with literal counts of o_v / o_busy.
    task automatic run_frame(input int n, input bit en_in, input int c,
                             input int e, input int k, input bit en_drop,
                             input int div, input int rst_at,
                             input int lit_v, input int lit_b,
                             input int s);
        int         vlen, g, bs, last;
        bit         padded, first, v_in, can_in, ena;
        logic [3:0] d_in;
        exp_t       x, hold;
        padded = en_in && (n < MIN);
        vlen   = padded ? MIN : n;
        bs     = padded ? n : vlen;
        g      = padded ? vlen + IFG - 1 : vlen + IFG;
        if (c >= 0) begin
            vlen = c;
            g    = c + IFG;
            if (c < bs) bs = c;
        end
        last = (e >= 0 && e + k - 1 > g) ? e + k - 1 : g;
        last += 2;
        first = 1'b1;
        for (int t = 0; t <= last; t++) begin
            v_in = (t < n && (c < 0 || t <= c)) ||
                   (e >= 0 && t >= e && t < e + k);
            d_in   = v_in ? pat(t, s) : 4'hF;
            can_in = (t == c);
            ena    = (en_drop && t > n) ? !en_in : en_in;
            hold       = last_exp;
            hold.ce    = 1'b0;
            hold.lit   = 1'b0;
            for (int j = 1; j < div; j++) begin
                hold.clr = first;
                first    = 1'b0;
                step(1'b0, 1'b0, v_in, d_in, can_in, ena, hold);
            end
            x.ce    = 1'b1;
            x.clr   = first;
            first   = 1'b0;
            x.lit   = 1'b0;
            x.lit_v = lit_v;
            x.lit_b = lit_b;
            if (t == rst_at) begin
                x.v     = 1'b0;
                x.d     = 4'h0;
                x.chk_d = 1'b1;
                x.busy  = 1'b0;
                x.err   = 1'b0;
                step(1'b1, 1'b1, v_in, d_in, can_in, ena, x);
                x.chk_d = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    x.lit = (j == 2);
                    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, en_in, x);
                end
                x.lit    = 1'b0;
                last_exp = x;
                break;
            end
            x.v     = (t < vlen);
            x.d     = (t < n) ? pat(t, s) : 4'h0;
            x.chk_d = x.v;
            x.busy  = (t >= bs) && (t < g);
            x.err   = (e >= 0) && (t >= e);
            x.lit   = (t == last);
            step(1'b1, 1'b0, v_in, d_in, can_in, ena, x);
            x.lit    = 1'b0;
            last_exp = x;
        end
    endtask

    initial begin
        exp_t z;
        rst    = 1'b1;
        ce     = 1'b1;
        en     = 1'b1;
        cancel = 1'b0;
        iv     = 1'b1;
        id     = 4'h5;
        z.ce    = 1'b0;
        z.v     = 1'b0;
        z.d     = 4'h0;
        z.chk_d = 1'b1;
        z.busy  = 1'b0;
        z.err   = 1'b0;
        z.clr   = 1'b0;
        z.lit   = 1'b0;
        z.lit_v = 0;
        z.lit_b = 0;
        // Reset wins over i_ce with i_v high.
        repeat (3) step(1'b1, 1'b1, 1'b1, 4'h5, 1'b0, 1'b1, z);
        repeat (2) step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, z);
        last_exp = z;

        run_frame(20,  1, -1, -1, 0, 0, 1, -1, 120, 123, 1);
        run_frame(150, 1, -1, -1, 0, 0, 1, -1, 150,  24, 2);
        run_frame(119, 1, -1, -1, 0, 0, 1, -1, 120,  24, 3);
        run_frame(120, 1, -1, -1, 0, 0, 1, -1, 120,  24, 4);
        run_frame(20,  0, -1, -1, 0, 0, 1, -1,  20,  24, 5);
        run_frame(20,  1, 10, -1, 0, 0, 1, -1,  10,  24, 6);
        run_frame(20,  1, 50, -1, 0, 0, 1, -1,  50,  54, 7);
        run_frame(30,  0, -1, 35, 3, 0, 1, -1,  30,  24, 8);
        run_frame(20,  0, -1, 44, 4, 0, 1, -1,  20,  24, 9);
        run_frame(25,  1, -1, -1, 0, 0, 1, -1, 120, 118, 10);
        run_frame(20,  1, -1, -1, 0, 1, 1, -1, 120, 123, 11);
        run_frame(20,  1, -1, -1, 0, 0, 4, 40,  40,  20, 12);
        run_frame(20,  1, -1, -1, 0, 0, 4, -1, 120, 123, 13);

        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) chk("queue_drain", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
